// File: rtl/alu_issue_ctrl.sv
// Issue/retire sequencer that feeds a combinational ALU from a sync-read register file and owns {C,N,Z}.
// Define ALU_ISSUE_FAST_EN to merge write-back into EXEC (3-cycle latency, 4 cycles per instruction).
// Opcodes [8:4]: ADD=0 ADDC=1 SUB=2 SUBC=3 LSL=4 LSLC=5 LSR=6 LSRC=7 AND=8 OR=9 XOR=10 NOT=11
// CMP=12 MOV=13; anything above MOV is not an ALU op.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RADDR_W   = 2,
  parameter int unsigned CARRY_REG = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               instr_valid_i,
  input  logic [8:0]         instr_i,
  output logic               instr_ready_o,
  output logic [RADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0]  rf_rdata_i,
  output logic               rf_we_o,
  output logic [RADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0]  rf_wdata_o,
  output logic [8:0]         alu_op_o,
  output logic [DATA_W-1:0]  alu_rs_o,
  output logic [DATA_W-1:0]  alu_rt_o,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic               alu_carry_i,
  input  logic               alu_neg_i,
  input  logic               alu_zero_i,
  output logic [2:0]         flags_o,
  output logic               done_o,
  output logic               illegal_o
);

  localparam logic [4:0] OpAddc = 5'd1;
  localparam logic [4:0] OpSubc = 5'd3;
  localparam logic [4:0] OpLslc = 5'd5;
  localparam logic [4:0] OpLsrc = 5'd7;
  localparam logic [4:0] OpCmp  = 5'd12;
  localparam logic [4:0] OpMov  = 5'd13;

  typedef enum logic [2:0] {StIdle, StRdRs, StRdRt, StExec, StWb} state_e;

  state_e              state_q, state_d;
  logic [8:0]          instr_q, instr_d;
  logic [RADDR_W-1:0]  raddr_q, raddr_d;
  logic [DATA_W-1:0]   rs_op_q, rs_op_d;
  logic [DATA_W-1:0]   rt_op_q, rt_op_d;
  logic [2:0]          flags_q, flags_d;
  logic                illegal_q, illegal_d;
`ifndef ALU_ISSUE_FAST_EN
  logic [DATA_W-1:0]   result_q, result_d;
`endif

  logic [4:0]          op;
  logic [RADDR_W-1:0]  rs_field, rt_field;
  logic                carry_class, is_cmp;
  logic [DATA_W-1:0]   rt_sel;
  logic                ready, we, done;
  logic [DATA_W-1:0]   alu_rt;

  assign op          = instr_q[8:4];
  assign rs_field    = instr_q[2 +: RADDR_W];
  assign rt_field    = instr_q[0 +: RADDR_W];
  assign carry_class = (op == OpAddc) || (op == OpSubc) || (op == OpLslc) || (op == OpLsrc);
  assign is_cmp      = (op == OpCmp);
  // Carry operand comes from the flags held at the start of EXEC, i.e. the previous retire.
  assign rt_sel      = (carry_class && (rt_field == RADDR_W'(CARRY_REG))) ?
                       {{(DATA_W-1){1'b0}}, flags_q[2]} : rf_rdata_i;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    raddr_d   = raddr_q;
    rs_op_d   = rs_op_q;
    rt_op_d   = rt_op_q;
    flags_d   = flags_q;
    illegal_d = 1'b0;
`ifndef ALU_ISSUE_FAST_EN
    result_d  = result_q;
`endif
    ready     = 1'b0;
    we        = 1'b0;
    done      = 1'b0;
    alu_rt    = rt_op_q;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (instr_valid_i) begin
          if (instr_i[8:4] <= OpMov) begin
            instr_d = instr_i;
            raddr_d = instr_i[2 +: RADDR_W];
            state_d = StRdRs;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StRdRs: begin
        raddr_d = rt_field;
        state_d = StRdRt;
      end
      StRdRt: begin
        rs_op_d = rf_rdata_i;
        state_d = StExec;
      end
      StExec: begin
        // The rt read data only arrives in this cycle, so the ALU sees it directly.
        rt_op_d = rt_sel;
        alu_rt  = rt_sel;
        flags_d = {alu_carry_i, alu_neg_i, alu_zero_i};
`ifdef ALU_ISSUE_FAST_EN
        we      = ~is_cmp;
        done    = 1'b1;
        state_d = StIdle;
`else
        result_d = alu_result_i;
        state_d  = StWb;
`endif
      end
      StWb: begin
        we      = ~is_cmp;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      raddr_q   <= '0;
      rs_op_q   <= '0;
      rt_op_q   <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
`ifndef ALU_ISSUE_FAST_EN
      result_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      raddr_q   <= raddr_d;
      rs_op_q   <= rs_op_d;
      rt_op_q   <= rt_op_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
`ifndef ALU_ISSUE_FAST_EN
      result_q  <= result_d;
`endif
    end
  end

  assign instr_ready_o = ready;
  assign rf_raddr_o    = raddr_q;
  assign rf_we_o       = we;
  assign rf_waddr_o    = rs_field;
`ifdef ALU_ISSUE_FAST_EN
  assign rf_wdata_o    = (state_q == StExec) ? alu_result_i : '0;
`else
  assign rf_wdata_o    = result_q;
`endif
  assign alu_op_o      = instr_q;
  assign alu_rs_o      = rs_op_q;
  assign alu_rt_o      = alu_rt;
  assign flags_o       = flags_q;
  assign done_o        = done;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a sync-read register file and a small ALU model.
// Honours ALU_ISSUE_FAST_EN for latency and issue spacing.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_FAST_EN
  localparam int Lat  = 3;
  localparam int NAcc = 4;
`else
  localparam int Lat  = 4;
  localparam int NAcc = 3;
`endif
  localparam int Per = Lat + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [8:0] instr;
  logic       ready;
  logic [1:0] raddr;
  logic [7:0] rdata;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [8:0] alu_op;
  logic [7:0] alu_s, alu_t, alu_r;
  logic       alu_c, alu_n, alu_z;
  logic [2:0] flags;
  logic       done, illegal;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rf [4];
  int         wr_cnt = 0;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(8), .RADDR_W(2), .CARRY_REG(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .instr_valid_i(valid), .instr_i(instr),
    .instr_ready_o(ready), .rf_raddr_o(raddr), .rf_rdata_i(rdata), .rf_we_o(we),
    .rf_waddr_o(waddr), .rf_wdata_o(wdata), .alu_op_o(alu_op), .alu_rs_o(alu_s),
    .alu_rt_o(alu_t), .alu_result_i(alu_r), .alu_carry_i(alu_c), .alu_neg_i(alu_n),
    .alu_zero_i(alu_z), .flags_o(flags), .done_o(done), .illegal_o(illegal)
  );

  always @(posedge clk) begin
    rdata <= rf[raddr];
    if (ld_en) rf[ld_addr] <= ld_data;
    else if (we) begin
      rf[waddr] <= wdata;
      wr_cnt    <= wr_cnt + 1;
    end
  end

  // ALU model: carry-class ops get their carry through operand t.
  logic [8:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (alu_op[8:4])
      5'd0, 5'd1:        alu_wide = {1'b0, alu_s} + {1'b0, alu_t};
      5'd2, 5'd3, 5'd12: alu_wide = {1'b0, alu_s} - {1'b0, alu_t};
      default:           alu_wide = {1'b0, alu_s & alu_t};
    endcase
    alu_r = alu_wide[7:0];
    alu_c = alu_wide[8];
    alu_n = alu_wide[7];
    alu_z = (alu_wide[7:0] == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Entered and left on a falling edge with the controller idle.
  task automatic run(input logic [4:0] op, input logic [1:0] rs, input logic [1:0] rt,
                     input logic [7:0] exp_s, input logic [7:0] exp_t, input logic exp_we,
                     input logic [7:0] exp_wd, input logic [2:0] exp_fl);
    chk("ready_idle", ready, 1);
    valid = 1'b1;
    instr = {op, rs, rt};
    @(negedge clk);
    valid = 1'b0;
    for (int c = 1; c <= Lat; c++) begin
      chk("done_timing", done, (c == Lat) ? 1 : 0);
      chk("ready_busy", ready, 0);
      if (c == 3) begin
        chk("alu_op", alu_op, {op, rs, rt});
        chk("alu_rs", alu_s, exp_s);
        chk("alu_rt", alu_t, exp_t);
      end
      if (c < Lat) chk("we_early", we, 0);
      else begin
        chk("we", we, exp_we);
        if (exp_we) begin
          chk("waddr", waddr, rs);
          chk("wdata", wdata, exp_wd);
        end
      end
      @(negedge clk);
    end
    chk("done_clear", done, 0);
    chk("we_clear", we, 0);
    chk("ready_back", ready, 1);
    chk("flags", flags, exp_fl);
    if (exp_we) chk("rf_written", rf[rs], exp_wd);
  endtask

  initial begin
    int w0;
    int acc[$];
    rst_n = 1'b0; valid = 1'b0; instr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_flags", flags, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_wdata", wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD r1,r2: 7F+01 -> 80, N set
    load(2'd1, 8'h7F); load(2'd2, 8'h01); load(2'd3, 8'h55);
    run(5'd0, 2'd1, 2'd2, 8'h7F, 8'h01, 1'b1, 8'h80, 3'b010);

    // ADD r0,r1: FF+01 -> 00 with C,Z; then ADDC r2,carry: 10+1 -> 11
    load(2'd0, 8'hFF); load(2'd1, 8'h01); load(2'd2, 8'h10);
    run(5'd0, 2'd0, 2'd1, 8'hFF, 8'h01, 1'b1, 8'h00, 3'b101);
    run(5'd1, 2'd2, 2'd3, 8'h10, 8'h01, 1'b1, 8'h11, 3'b000);

    // CMP r0,r1 equal: flags only
    load(2'd0, 8'h22); load(2'd1, 8'h22);
    w0 = wr_cnt;
    run(5'd12, 2'd0, 2'd1, 8'h22, 8'h22, 1'b0, 8'h00, 3'b001);
    chk("cmp_no_write", wr_cnt, w0);
    chk("cmp_r0_kept", rf[0], 8'h22);

    // Non-ALU opcode
    w0 = wr_cnt;
    valid = 1'b1;
    instr = {5'h1F, 2'd1, 2'd2};
    @(negedge clk);
    valid = 1'b0;
    chk("ill_pulse", illegal, 1);
    chk("ill_ready", ready, 1);
    chk("ill_we", we, 0);
    chk("ill_flags", flags, 3'b001);
    @(negedge clk);
    chk("ill_clear", illegal, 0);
    chk("ill_no_write", wr_cnt, w0);

    // Reset during EXEC
    w0 = wr_cnt;
    valid = 1'b1;
    instr = {5'd0, 2'd1, 2'd2};
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_op", alu_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_write", wr_cnt, w0);
    chk("mid_rst_r1", rf[1], 8'h22);

    // Valid held high: accepts must be evenly spaced
    valid = 1'b1;
    instr = {5'd8, 2'd0, 2'd0};
    for (int c = 0; c < 14; c++) begin
      if (ready) acc.push_back(c);
      @(negedge clk);
    end
    valid = 1'b0;
    chk("held_accepts", acc.size(), NAcc);
    if (acc.size() >= 3) begin
      chk("held_gap0", acc[1] - acc[0], Per);
      chk("held_gap1", acc[2] - acc[1], Per);
    end
    repeat (4) @(negedge clk);
    chk("held_idle", ready, 1);
    chk("held_r0", rf[0], 8'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
